en_ctl_multi: RTL and testbench

Multi-channel, parametrised enable controller that sits between the host-side enable register bank and the UART RX/TX channel cores. After a configurable start-up hold-off, each channel runs its own enable state machine. The machine produces a clock-enable, qualified read/write strobes and a fixed-width channel reset pulse when the channel is disabled. It also records strobes that arrive while a channel is not running.

---
 rtl/en_ctl_multi.sv | 139 +++++++++++++
 tb/tb_en_ctl_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/en_ctl_multi.sv
// Multi-channel enable controller: start-up hold-off, per-channel OFF/ON/RST machine,
// strobe qualification and sticky drop flags. Optional `EN_CTL_SYNC_EN adds a 2-flop en synchroniser.
module en_ctl_multi #(
   parameter int CH          = 2,
   parameter int STARTUP_CYC = 16,
   parameter int RST_CYC     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] en,
   input  logic [CH-1:0] rx_read,
   input  logic [CH-1:0] tx_write,
   input  logic [CH-1:0] drop_clr,
   output logic          ready,
   output logic [CH-1:0] clk_en,
   output logic [CH-1:0] rst_ch,
   output logic [CH-1:0] rx_read_buf,
   output logic [CH-1:0] tx_write_buf,
   output logic [CH-1:0] drop
);

   localparam int CW = $clog2(STARTUP_CYC + 1);
   localparam int TW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [CW-1:0] START_MAX  = CW'(STARTUP_CYC);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(RST_CYC - 1);

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ON  = 2'd1,
      ST_RST = 2'd2
   } state_t;

   logic [CW-1:0] start_cnt_reg;
   logic [CW-1:0] start_cnt_next;
   logic          ready_reg;

   // Saturating hold-off counter; ready is registered alongside it so both change on the same edge.
   always_comb begin
      start_cnt_next = start_cnt_reg;
      if (start_cnt_reg != START_MAX) begin
         start_cnt_next = start_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_cnt_reg <= '0;
         ready_reg     <= 1'b0;
      end else begin
         start_cnt_reg <= start_cnt_next;
         ready_reg     <= (start_cnt_next == START_MAX);
      end
   end

   assign ready = ready_reg;

   logic [CH-1:0] en_fsm;

`ifdef EN_CTL_SYNC_EN
   logic [CH-1:0] en_meta_reg;
   logic [CH-1:0] en_sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_meta_reg <= '0;
         en_sync_reg <= '0;
      end else begin
         en_meta_reg <= en;
         en_sync_reg <= en_meta_reg;
      end
   end

   assign en_fsm = en_sync_reg;
`else
   assign en_fsm = en;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         state_t        state_reg;
         logic [TW-1:0] timer_reg;
         logic          drop_reg;
         logic          is_on;

         assign is_on = (state_reg == ST_ON);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg <= ST_OFF;
               timer_reg <= '0;
            end else begin
               case (state_reg)
                  ST_OFF: begin
                     if (ready_reg && en_fsm[gi]) begin
                        state_reg <= ST_ON;
                     end
                  end
                  ST_ON: begin
                     if (!en_fsm[gi]) begin
                        state_reg <= ST_RST;
                        timer_reg <= TIMER_LOAD;
                     end
                  end
                  ST_RST: begin
                     // en is deliberately ignored until the pulse has run its full width.
                     if (timer_reg == '0) begin
                        state_reg <= ST_OFF;
                     end else begin
                        timer_reg <= timer_reg - 1'b1;
                     end
                  end
                  default: begin
                     state_reg <= ST_OFF;
                  end
               endcase
            end
         end

         // A new drop event takes priority over a clear arriving in the same cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               drop_reg <= 1'b0;
            end else if ((rx_read[gi] || tx_write[gi]) && !is_on) begin
               drop_reg <= 1'b1;
            end else if (drop_clr[gi]) begin
               drop_reg <= 1'b0;
            end
         end

         assign clk_en[gi]       = is_on;
         assign rst_ch[gi]       = (state_reg == ST_RST) || ((state_reg == ST_OFF) && !ready_reg);
         assign rx_read_buf[gi]  = rx_read[gi] && is_on;
         assign tx_write_buf[gi] = tx_write[gi] && is_on;
         assign drop[gi]         = drop_reg;
      end
   endgenerate

endmodule

// File: tb/tb_en_ctl_multi.sv
// Scoreboard bench for en_ctl_multi: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares. Honours `EN_CTL_SYNC_EN in the model.
module tb_en_ctl_multi;

   localparam int CH          = 2;
   localparam int STARTUP_CYC = 16;
   localparam int RST_CYC     = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] en = '0;
   logic [CH-1:0] rx_read = '0;
   logic [CH-1:0] tx_write = '0;
   logic [CH-1:0] drop_clr = '0;
   logic          ready;
   logic [CH-1:0] clk_en;
   logic [CH-1:0] rst_ch;
   logic [CH-1:0] rx_read_buf;
   logic [CH-1:0] tx_write_buf;
   logic [CH-1:0] drop;

   en_ctl_multi #(
      .CH(CH),
      .STARTUP_CYC(STARTUP_CYC),
      .RST_CYC(RST_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .rx_read(rx_read),
      .tx_write(tx_write),
      .drop_clr(drop_clr),
      .ready(ready),
      .clk_en(clk_en),
      .rst_ch(rst_ch),
      .rx_read_buf(rx_read_buf),
      .tx_write_buf(tx_write_buf),
      .drop(drop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          ready;
      logic [CH-1:0] clk_en;
      logic [CH-1:0] rst_ch;
      logic [CH-1:0] rxb;
      logic [CH-1:0] txb;
      logic [CH-1:0] drop;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model: cycles since reset, per-channel "running" flag, remaining reset-pulse cycles.
   int edges_since_rst;
   bit m_on   [CH];
   int m_left [CH];
   bit m_drop [CH];
   bit m_s1   [CH];
   bit m_s2   [CH];

   function automatic void model_reset();
      edges_since_rst = 0;
      for (int i = 0; i < CH; i++) begin
         m_on[i] = 0; m_left[i] = 0; m_drop[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
   endfunction

   function automatic bit model_ready();
      return edges_since_rst >= STARTUP_CYC;
   endfunction

   // Advance one clock edge using the inputs currently applied to the DUT.
   function automatic void model_edge();
      bit rdy;
      bit e;
      if (rst) begin
         model_reset();
         return;
      end
      rdy = model_ready();
      for (int i = 0; i < CH; i++) begin
`ifdef EN_CTL_SYNC_EN
         e = m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = en[i];
`else
         e = en[i];
`endif
         if ((rx_read[i] || tx_write[i]) && !m_on[i]) m_drop[i] = 1;
         else if (drop_clr[i]) m_drop[i] = 0;
         if (m_left[i] > 0) begin
            m_left[i]--;
         end else if (m_on[i]) begin
            if (!e) begin
               m_on[i] = 0;
               m_left[i] = RST_CYC;
            end
         end else if (rdy && e) begin
            m_on[i] = 1;
         end
      end
      if (edges_since_rst < STARTUP_CYC) edges_since_rst++;
   endfunction

   function automatic exp_t model_out();
      exp_t x;
      x.ready = model_ready();
      for (int i = 0; i < CH; i++) begin
         x.clk_en[i] = m_on[i];
         x.rst_ch[i] = (m_left[i] > 0) || (!m_on[i] && !x.ready);
         x.rxb[i]    = rx_read[i] && m_on[i];
         x.txb[i]    = tx_write[i] && m_on[i];
         x.drop[i]   = m_drop[i];
      end
      return x;
   endfunction

   task automatic step(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] rx,
                       input logic [CH-1:0] tx, input logic [CH-1:0] clr);
      @(posedge clk);
      model_edge();
      #1;
      rst = r; en = e; rx_read = rx; tx_write = tx; drop_clr = clr;
      if (r) model_reset();
      q.push_back(model_out());
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output vector.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            x = q.pop_front();
            check("ready", 32'(ready), 32'(x.ready));
            check("clk_en", 32'(clk_en), 32'(x.clk_en));
            check("rst_ch", 32'(rst_ch), 32'(x.rst_ch));
            check("rx_read_buf", 32'(rx_read_buf), 32'(x.rxb));
            check("tx_write_buf", 32'(tx_write_buf), 32'(x.txb));
            check("drop", 32'(drop), 32'(x.drop));
            $display("cyc %0d rst=%b en=%b rx=%b tx=%b clr=%b | rdy=%b clk_en=%b rst_ch=%b rxb=%b txb=%b drop=%b",
                     cyc, rst, en, rx_read, tx_write, drop_clr, ready, clk_en, rst_ch,
                     rx_read_buf, tx_write_buf, drop);
         end
      end
   end

   initial begin
      logic [CH-1:0] e;
      logic          r;
      model_reset();
      // Hold-off with en held high from reset release.
      for (int k = 0; k < 3; k++) step(1'b1, 2'b11, '0, '0, '0);
      for (int k = 0; k < 20; k++) step(1'b0, 2'b11, '0, '0, '0);
      // Disable channel 1, then cycle channel 0 off and on.
      for (int k = 0; k < 8; k++) step(1'b0, 2'b01, '0, '0, '0);
      for (int k = 0; k < 8; k++) step(1'b0, 2'b00, '0, '0, '0);
      for (int k = 0; k < 4; k++) step(1'b0, 2'b01, '0, '0, '0);
      // Strobe qualification and drop set/clear priority.
      step(1'b0, 2'b01, 2'b01, 2'b10, 2'b00);
      step(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
      step(1'b0, 2'b01, 2'b00, 2'b00, 2'b10);
      step(1'b0, 2'b01, 2'b00, 2'b10, 2'b10);
      step(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
      step(1'b0, 2'b01, 2'b11, 2'b11, 2'b00);
      // Re-enable during the reset pulse.
      step(1'b0, 2'b00, '0, '0, '0);
      for (int k = 0; k < 10; k++) step(1'b0, 2'b01, 2'b01, '0, '0);
      // Reset mid-operation with both channels running.
      for (int k = 0; k < 6; k++) step(1'b0, 2'b11, '0, '0, '0);
      step(1'b1, 2'b11, 2'b11, 2'b11, '0);
      step(1'b1, 2'b11, '0, '0, '0);
      for (int k = 0; k < 20; k++) step(1'b0, 2'b11, '0, '0, '0);
      // Randomised traffic with slowly changing enables and occasional resets.
      e = 2'b11;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 5) == 0) e[$urandom_range(0, CH - 1)] ^= 1'b1;
         r = ($urandom_range(0, 149) == 0);
         step(r, e, CH'($urandom), CH'($urandom),
              CH'($urandom) & CH'($urandom));
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
